lsu_stage: RTL and testbench
============================

LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 The block SHALL have parameter BITSIZE, default 32, meaning datapath width in bits (legal values 32 or 64).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles to wait for MEM_valid_i before aborting.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 resetn_i  in  1  reset, synchronous and active-low.
REQ-005 EX_MEM_give_i  in  1  EX presents an instruction.
REQ-006 MEM_EX_get_o  out  1  stage ready to accept from EX.
REQ-007 EX_MEM_instr_i  in  32  instruction word.
REQ-008 EX_MEM_result_i  in  BITSIZE  ALU result, or the byte address for load/store.
REQ-009 EX_MEM_rs2_i  in  BITSIZE  store data.
REQ-010 MEM_addr_o  out  BITSIZE  byte address.
REQ-011 MEM_data_o  out  BITSIZE  lane-aligned store data.
REQ-012 MEM_be_o  out  BITSIZE/8  byte enables.
REQ-013 MEM_read_o / MEM_write_o  out  1 each  access request strobes.
REQ-014 MEM_data_i  in  BITSIZE  read data.
REQ-015 MEM_valid_i  in  1  access complete.
REQ-016 WB_MEM_get_i  in  1  WB ready.
REQ-017 MEM_WB_give_o  out  1  result valid to WB.
REQ-018 MEM_WB_instr_o  out  32  held instruction.
REQ-019 MEM_WB_data_o  out  BITSIZE  result data.
REQ-020 MEM_WB_err_o  out  1  access fault flag.

Function
REQ-021 The FSM SHALL have states IDLE, ACCESS and WB. In IDLE, MEM_EX_get_o=1, and EX_MEM_give_i=1 latches the instruction, address and store data into registers.
REQ-022 From IDLE, opcode 0000011 (LOAD) or 0100011 (STORE) SHALL go to ACCESS; any other opcode SHALL go to WB with data=EX_MEM_result_i and err=0.
REQ-023 Access size SHALL be 2^funct3[1:0] bytes; funct3[1:0]=11 with BITSIZE=32 SHALL be illegal, skipping ACCESS and going to WB with err=1 and data=address.
REQ-024 The byte offset is the address low log2(BITSIZE/8) bits. MEM_be_o SHALL be the size mask shifted left by the offset; MEM_data_o SHALL be rs2 shifted left by 8*offset.
REQ-025 In ACCESS, MEM_read_o (load) or MEM_write_o (store) SHALL be held high until MEM_valid_i; on MEM_valid_i the block SHALL drop the strobe the next cycle and go to WB.
REQ-026 Load data SHALL be MEM_data_i shifted right by 8*offset, then sign-extended from the access size, or zero-extended when funct3[2]=1. Store data to WB SHALL be 0.
REQ-027 A cycle counter SHALL clear on entry to ACCESS; if it reaches TIMEOUT without MEM_valid_i, the block SHALL drop the strobe, go to WB with err=1 and data=0, and ignore any late MEM_valid_i.
REQ-028 In WB, MEM_WB_give_o=1 and outputs SHALL be held stable. WB_MEM_get_i=1 SHALL return the FSM to IDLE the next cycle.
REQ-029 A new instruction SHALL NOT be accepted in the same cycle as a WB handoff.
REQ-030 Latency SHALL be: non-memory, accepted at cycle N, give at N+1; memory, MEM_valid_i at cycle K, give at K+1.
REQ-031 All outputs SHALL be registered, except MEM_EX_get_o, which SHALL be decoded from state.

Reset
REQ-032 With resetn_i=0 at a clock edge: state=IDLE, counter=0, strobes=0, MEM_be_o=0, MEM_WB_give_o=0, MEM_WB_err_o=0, all data, address and instruction outputs=0.
REQ-033 Reset during ACCESS SHALL drop the strobes in the following cycle and discard the pending instruction.

Configuration
REQ-034 Macro LSU_MISALIGN_TRAP_EN, when defined: if address mod size != 0, the block SHALL skip ACCESS and go to WB with err=1 and data=address.
REQ-035 Macro LSU_MISALIGN_TRAP_EN, when undefined: the address SHALL be rounded down to the size boundary before the offset is computed, the access SHALL proceed, and misalignment SHALL never set err.

Verification
REQ-036 Test 1: ADDI result 0x1234, WB_MEM_get_i=1 -> give one cycle after accept, data=0x1234, err=0, no strobes.
REQ-037 Test 2: LB at 0x103, MEM_data_i=0x80FFFFFF -> MEM_be_o=1000, WB data=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-038 Test 3: SH at 0x102, rs2=0xABCD -> MEM_data_o=0xABCD0000, MEM_be_o=1100, MEM_write_o held until MEM_valid_i.
REQ-039 Test 4: LW, MEM_valid_i never asserted, TIMEOUT=4 -> strobe drops after 4 cycles, err=1, data=0.
REQ-040 Test 5: LW at 0x101 -> with LSU_MISALIGN_TRAP_EN: err=1, data=0x101, no strobe; without it: access issued at address 0x100.
REQ-041 Test 6: resetn_i=0 mid-ACCESS, then WB_MEM_get_i=0 held -> strobes drop, FSM in IDLE, no give.

Source files
------------

// File: rtl/lsu_stage.sv
// Load/store pipeline stage: takes one instruction from EX, performs at most one memory access, hands the result to WB.
// Latency: non-memory ops give to WB the cycle after accept; memory ops give the cycle after MEM_valid_i (or after TIMEOUT).
// Backpressure: one instruction in flight; MEM_EX_get_o is high only in IDLE, and WB holds all outputs until WB_MEM_get_i.
//
// Ports:
//   clk, resetn_i                    clock, synchronous active-low reset
//   EX_MEM_give_i / MEM_EX_get_o     EX handshake; EX_MEM_instr_i, EX_MEM_result_i (ALU result or byte address), EX_MEM_rs2_i (store data)
//   MEM_addr_o, MEM_data_o, MEM_be_o memory request: address, lane-aligned store data, byte enables
//   MEM_read_o / MEM_write_o         request strobes, held until MEM_valid_i or timeout
//   MEM_data_i, MEM_valid_i          memory response
//   MEM_WB_give_o / WB_MEM_get_i     WB handshake; MEM_WB_instr_o, MEM_WB_data_o, MEM_WB_err_o
//
// Build option: define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of rounding the address down.
module lsu_stage #(
    parameter int BITSIZE = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 resetn_i,
    input  logic                 EX_MEM_give_i,
    output logic                 MEM_EX_get_o,
    input  logic [31:0]          EX_MEM_instr_i,
    input  logic [BITSIZE-1:0]   EX_MEM_result_i,
    input  logic [BITSIZE-1:0]   EX_MEM_rs2_i,
    output logic [BITSIZE-1:0]   MEM_addr_o,
    output logic [BITSIZE-1:0]   MEM_data_o,
    output logic [BITSIZE/8-1:0] MEM_be_o,
    output logic                 MEM_read_o,
    output logic                 MEM_write_o,
    input  logic [BITSIZE-1:0]   MEM_data_i,
    input  logic                 MEM_valid_i,
    input  logic                 WB_MEM_get_i,
    output logic                 MEM_WB_give_o,
    output logic [31:0]          MEM_WB_instr_o,
    output logic [BITSIZE-1:0]   MEM_WB_data_o,
    output logic                 MEM_WB_err_o
);

    localparam int NB   = BITSIZE / 8;
    localparam int OFFW = $clog2(NB);
    // Counter only needs to reach TIMEOUT-1: the timeout fires on the edge that ends that cycle.
    localparam int CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WB     = 2'd2;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic [1:0]    state;
    logic [CW-1:0] cnt;

    // Request decode from the EX inputs
    logic [6:0]         ex_op;
    logic [2:0]         ex_f3;
    logic               ex_is_mem;
    logic               size_illegal;
    logic               trap;
    logic [BITSIZE-1:0] size_m1;
    logic [BITSIZE-1:0] aligned_addr;
    logic [OFFW-1:0]    ex_off;
    logic [NB-1:0]      size_mask;
    logic [NB-1:0]      be_next;
    logic [BITSIZE-1:0] wdata_next;

    always_comb begin
        ex_op        = EX_MEM_instr_i[6:0];
        ex_f3        = EX_MEM_instr_i[14:12];
        ex_is_mem    = (ex_op == OP_LOAD) || (ex_op == OP_STORE);
        size_illegal = (ex_f3[1:0] == 2'b11) && (BITSIZE == 32);
        case (ex_f3[1:0])
            2'b00:   size_mask = NB'(8'h01);
            2'b01:   size_mask = NB'(8'h03);
            2'b10:   size_mask = NB'(8'h0F);
            default: size_mask = NB'(8'hFF);
        endcase
        size_m1      = (BITSIZE'(1) << ex_f3[1:0]) - BITSIZE'(1);
        // Rounding down is a no-op for aligned addresses, so the trap build can share it.
        aligned_addr = EX_MEM_result_i & ~size_m1;
        ex_off       = aligned_addr[OFFW-1:0];
        be_next      = size_mask << ex_off;
        wdata_next   = EX_MEM_rs2_i << {ex_off, 3'b000};
`ifdef LSU_MISALIGN_TRAP_EN
        trap         = size_illegal || (|(EX_MEM_result_i & size_m1));
`else
        trap         = size_illegal;
`endif
    end

    // Load data extraction; size and offset come from the held instruction and address
    logic [2:0]         acc_f3;
    logic [OFFW-1:0]    acc_off;
    logic [BITSIZE-1:0] rd_shift;
    logic [BITSIZE-1:0] rd_mask;
    logic               rd_sign;
    logic [BITSIZE-1:0] load_data;

    always_comb begin
        acc_f3   = MEM_WB_instr_o[14:12];
        acc_off  = MEM_addr_o[OFFW-1:0];
        rd_shift = MEM_data_i >> {acc_off, 3'b000};
        case (acc_f3[1:0])
            2'b00: begin
                rd_mask = BITSIZE'(64'h0000_0000_0000_00FF);
                rd_sign = rd_shift[7];
            end
            2'b01: begin
                rd_mask = BITSIZE'(64'h0000_0000_0000_FFFF);
                rd_sign = rd_shift[15];
            end
            2'b10: begin
                rd_mask = BITSIZE'(64'h0000_0000_FFFF_FFFF);
                rd_sign = rd_shift[31];
            end
            default: begin
                rd_mask = '1;
                rd_sign = rd_shift[BITSIZE-1];
            end
        endcase
        // funct3[2] selects zero extension
        load_data = (rd_shift & rd_mask) | ((rd_sign && !acc_f3[2]) ? ~rd_mask : '0);
    end

    assign MEM_EX_get_o = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (!resetn_i) begin
            state          <= S_IDLE;
            cnt            <= '0;
            MEM_addr_o     <= '0;
            MEM_data_o     <= '0;
            MEM_be_o       <= '0;
            MEM_read_o     <= 1'b0;
            MEM_write_o    <= 1'b0;
            MEM_WB_give_o  <= 1'b0;
            MEM_WB_instr_o <= '0;
            MEM_WB_data_o  <= '0;
            MEM_WB_err_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (EX_MEM_give_i) begin
                        MEM_WB_instr_o <= EX_MEM_instr_i;
                        if (!ex_is_mem) begin
                            MEM_WB_data_o <= EX_MEM_result_i;
                            MEM_WB_err_o  <= 1'b0;
                            MEM_WB_give_o <= 1'b1;
                            state         <= S_WB;
                        end else if (trap) begin
                            // Faulting access: report the offending address, touch no memory
                            MEM_WB_data_o <= EX_MEM_result_i;
                            MEM_WB_err_o  <= 1'b1;
                            MEM_WB_give_o <= 1'b1;
                            state         <= S_WB;
                        end else begin
                            MEM_addr_o  <= aligned_addr;
                            MEM_be_o    <= be_next;
                            MEM_data_o  <= wdata_next;
                            MEM_read_o  <= (ex_op == OP_LOAD);
                            MEM_write_o <= (ex_op == OP_STORE);
                            cnt         <= '0;
                            state       <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (MEM_valid_i) begin
                        MEM_read_o    <= 1'b0;
                        MEM_write_o   <= 1'b0;
                        MEM_WB_data_o <= MEM_read_o ? load_data : '0;
                        MEM_WB_err_o  <= 1'b0;
                        MEM_WB_give_o <= 1'b1;
                        state         <= S_WB;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        // Abandon the access; a late MEM_valid_i lands in WB and is ignored there
                        MEM_read_o    <= 1'b0;
                        MEM_write_o   <= 1'b0;
                        MEM_WB_data_o <= '0;
                        MEM_WB_err_o  <= 1'b1;
                        MEM_WB_give_o <= 1'b1;
                        state         <= S_WB;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WB: begin
                    if (WB_MEM_get_i) begin
                        MEM_WB_give_o <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_stage.sv
// Testbench for lsu_stage: directed vector table plus randomized transactions against a reference model.
// Latency: checks give timing per transaction (accept+1 or MEM_valid_i+1, timeout after TIMEOUT strobe cycles).
// Backpressure: holds WB_MEM_get_i low for random spans and offers new EX work while in WB.
module tb_lsu_stage;

    localparam int BITSIZE = 32;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        resetn_i;
    logic        EX_MEM_give_i;
    logic        MEM_EX_get_o;
    logic [31:0] EX_MEM_instr_i;
    logic [31:0] EX_MEM_result_i;
    logic [31:0] EX_MEM_rs2_i;
    logic [31:0] MEM_addr_o;
    logic [31:0] MEM_data_o;
    logic [3:0]  MEM_be_o;
    logic        MEM_read_o;
    logic        MEM_write_o;
    logic [31:0] MEM_data_i;
    logic        MEM_valid_i;
    logic        WB_MEM_get_i;
    logic        MEM_WB_give_o;
    logic [31:0] MEM_WB_instr_o;
    logic [31:0] MEM_WB_data_o;
    logic        MEM_WB_err_o;

    lsu_stage #(.BITSIZE(BITSIZE), .TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .resetn_i        (resetn_i),
        .EX_MEM_give_i   (EX_MEM_give_i),
        .MEM_EX_get_o    (MEM_EX_get_o),
        .EX_MEM_instr_i  (EX_MEM_instr_i),
        .EX_MEM_result_i (EX_MEM_result_i),
        .EX_MEM_rs2_i    (EX_MEM_rs2_i),
        .MEM_addr_o      (MEM_addr_o),
        .MEM_data_o      (MEM_data_o),
        .MEM_be_o        (MEM_be_o),
        .MEM_read_o      (MEM_read_o),
        .MEM_write_o     (MEM_write_o),
        .MEM_data_i      (MEM_data_i),
        .MEM_valid_i     (MEM_valid_i),
        .WB_MEM_get_i    (WB_MEM_get_i),
        .MEM_WB_give_o   (MEM_WB_give_o),
        .MEM_WB_instr_o  (MEM_WB_instr_o),
        .MEM_WB_data_o   (MEM_WB_data_o),
        .MEM_WB_err_o    (MEM_WB_err_o)
    );

    always #5 clk = ~clk;

    // One transaction: stimulus plus everything the stage should show for it.
    // delay = cycles into ACCESS before MEM_valid_i is pulsed; negative = never.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] result;
        logic [31:0] rs2;
        logic [31:0] mem;
        int          delay;
        logic        acc;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] data;
    } vec_t;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
        return {12'h0A5, 5'd2, f3, 5'd7, op};
    endfunction

    function automatic vec_t mkv(input logic [31:0] instr, result, rs2, mem, input int delay,
                                 input logic acc, rd, wr, input logic [31:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata,
                                 input logic err, input logic [31:0] data);
        vec_t v;
        v.instr = instr; v.result = result; v.rs2 = rs2; v.mem = mem; v.delay = delay;
        v.acc = acc; v.rd = rd; v.wr = wr; v.addr = addr; v.be = be; v.wdata = wdata;
        v.err = err; v.data = data;
        return v;
    endfunction

    // Reference model: expected behaviour computed arithmetically from size/offset rules.
    function automatic vec_t model(input logic [31:0] instr, result, rs2, mem, input int delay);
        vec_t e;
        int op, f3, size;
        longint unsigned r, a, off, v, full, m, s;
        e = mkv(instr, result, rs2, mem, delay, 0, 0, 0, 0, 0, 0, 0, 0);
        op = int'(instr[6:0]);
        f3 = int'(instr[14:12]);
        r  = result;
        if (op != 3 && op != 35) begin
            e.data = result;
            return e;
        end
        size = 1 << (f3 % 4);
        if (size > 4) begin
            e.err = 1; e.data = result;
            return e;
        end
`ifdef LSU_MISALIGN_TRAP_EN
        if (r % size != 0) begin
            e.err = 1; e.data = result;
            return e;
        end
`endif
        a   = r - (r % size);
        off = a % 4;
        e.acc   = 1;
        e.rd    = (op == 3);
        e.wr    = (op == 35);
        e.addr  = 32'(a);
        e.be    = 4'(((64'd1 << size) - 1) << off);
        s       = rs2;
        e.wdata = 32'(s << (8 * off));
        if (delay < 0 || delay >= TIMEOUT) begin
            e.err = 1; e.data = 0;
        end else if (op == 35) begin
            e.data = 0;
        end else begin
            full = 64'd1 << (8 * size);
            m    = mem;
            v    = (m >> (8 * off)) % full;
            if (f3 < 4 && v >= full / 2) v = v + 64'h1_0000_0000 - full;
            e.data = 32'(v);
        end
        return e;
    endfunction

    task automatic run_vec(input string tag, input vec_t v);
        int stop, hold;
        chk({tag, ".get_idle"}, 32'(MEM_EX_get_o), 32'd1);
        EX_MEM_give_i   = 1'b1;
        EX_MEM_instr_i  = v.instr;
        EX_MEM_result_i = v.result;
        EX_MEM_rs2_i    = v.rs2;
        tick();
        EX_MEM_give_i   = 1'b0;
        EX_MEM_instr_i  = $urandom;
        EX_MEM_result_i = $urandom;
        EX_MEM_rs2_i    = $urandom;
        if (v.acc) begin
            stop = (v.delay >= 0 && v.delay < TIMEOUT) ? v.delay + 1 : TIMEOUT;
            for (int c = 0; c < stop; c++) begin
                chk($sformatf("%s.rd%0d", tag, c), 32'(MEM_read_o), 32'(v.rd));
                chk($sformatf("%s.wr%0d", tag, c), 32'(MEM_write_o), 32'(v.wr));
                chk($sformatf("%s.give%0d", tag, c), 32'(MEM_WB_give_o), 32'd0);
                if (c == 0) begin
                    chk({tag, ".addr"}, MEM_addr_o, v.addr);
                    chk({tag, ".be"}, 32'(MEM_be_o), 32'(v.be));
                    chk({tag, ".wdata"}, MEM_data_o, v.wdata);
                    chk({tag, ".get_busy"}, 32'(MEM_EX_get_o), 32'd0);
                end
                MEM_valid_i = (c == v.delay);
                MEM_data_i  = (c == v.delay) ? v.mem : $urandom;
                tick();
            end
            MEM_valid_i = 1'b0;
        end
        chk({tag, ".strobes_off"}, {30'd0, MEM_read_o, MEM_write_o}, 32'd0);
        chk({tag, ".give"}, 32'(MEM_WB_give_o), 32'd1);
        chk({tag, ".err"}, 32'(MEM_WB_err_o), 32'(v.err));
        chk({tag, ".data"}, MEM_WB_data_o, v.data);
        chk({tag, ".instr"}, MEM_WB_instr_o, v.instr);
        chk({tag, ".get_wb"}, 32'(MEM_EX_get_o), 32'd0);
        // WB stall: outputs hold; late memory responses and new EX work must be ignored
        hold = $urandom_range(0, 2);
        EX_MEM_give_i = 1'b1;
        for (int h = 0; h < hold; h++) begin
            MEM_valid_i = $urandom_range(0, 1);
            MEM_data_i  = $urandom;
            tick();
            chk($sformatf("%s.hold_give%0d", tag, h), 32'(MEM_WB_give_o), 32'd1);
            chk($sformatf("%s.hold_data%0d", tag, h), MEM_WB_data_o, v.data);
            chk($sformatf("%s.hold_err%0d", tag, h), 32'(MEM_WB_err_o), 32'(v.err));
        end
        MEM_valid_i  = 1'b0;
        WB_MEM_get_i = 1'b1;
        tick();
        WB_MEM_get_i  = 1'b0;
        EX_MEM_give_i = 1'b0;
        chk({tag, ".handoff_give"}, 32'(MEM_WB_give_o), 32'd0);
        chk({tag, ".handoff_idle"}, 32'(MEM_EX_get_o), 32'd1);
    endtask

    vec_t vecs[13];

    initial begin
        vec_t rv;
        int   kind, f3, op;
        logic [31:0] instr, res;
        logic [6:0]  nm_ops[4];

        nm_ops = '{7'h13, 7'h33, 7'h37, 7'h6F};

        vecs[0]  = mkv(mk(7'h13, 3'd0), 32'h1234, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h1234);
        vecs[1]  = mkv(mk(7'h03, 3'd0), 32'h103, 32'h0, 32'h80FF_FFFF, 2, 1, 1, 0, 32'h103, 4'b1000, 32'h0, 0, 32'hFFFF_FF80);
        vecs[2]  = mkv(mk(7'h03, 3'd4), 32'h103, 32'h0, 32'h80FF_FFFF, 0, 1, 1, 0, 32'h103, 4'b1000, 32'h0, 0, 32'h0000_0080);
        vecs[3]  = mkv(mk(7'h23, 3'd1), 32'h102, 32'hABCD, 32'h0, 3, 1, 0, 1, 32'h102, 4'b1100, 32'hABCD_0000, 0, 32'h0);
        vecs[4]  = mkv(mk(7'h03, 3'd2), 32'h200, 32'h0, 32'h5555, -1, 1, 1, 0, 32'h200, 4'b1111, 32'h0, 1, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[5]  = mkv(mk(7'h03, 3'd2), 32'h101, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h101);
`else
        vecs[5]  = mkv(mk(7'h03, 3'd2), 32'h101, 32'h0, 32'hDEAD_BEEF, 0, 1, 1, 0, 32'h100, 4'b1111, 32'h0, 0, 32'hDEAD_BEEF);
`endif
        vecs[6]  = mkv(mk(7'h03, 3'd3), 32'h40, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h40);
        vecs[7]  = mkv(mk(7'h03, 3'd5), 32'h106, 32'h0, 32'h9ABC_1234, 1, 1, 1, 0, 32'h106, 4'b1100, 32'h0, 0, 32'h0000_9ABC);
        vecs[8]  = mkv(mk(7'h03, 3'd1), 32'h106, 32'h0, 32'h9ABC_1234, 1, 1, 1, 0, 32'h106, 4'b1100, 32'h0, 0, 32'hFFFF_9ABC);
        vecs[9]  = mkv(mk(7'h23, 3'd2), 32'h300, 32'h1122_3344, 32'h0, 1, 1, 0, 1, 32'h300, 4'b1111, 32'h1122_3344, 0, 32'h0);
        vecs[10] = mkv(mk(7'h23, 3'd0), 32'h301, 32'hFFFF_FF5A, 32'h0, 0, 1, 0, 1, 32'h301, 4'b0010, 32'hFFFF_5A00, 0, 32'h0);
        vecs[11] = mkv(mk(7'h03, 3'd2), 32'h10, 32'h0, 32'h1234_5678, 3, 1, 1, 0, 32'h10, 4'b1111, 32'h0, 0, 32'h1234_5678);
        vecs[12] = mkv(mk(7'h23, 3'd2), 32'h20, 32'hCAFE_F00D, 32'h0, 4, 1, 0, 1, 32'h20, 4'b1111, 32'hCAFE_F00D, 1, 32'h0);

        // Reset with junk on the inputs
        resetn_i        = 1'b0;
        EX_MEM_give_i   = 1'b1;
        EX_MEM_instr_i  = mk(7'h03, 3'd2);
        EX_MEM_result_i = 32'h44;
        EX_MEM_rs2_i    = $urandom;
        MEM_data_i      = $urandom;
        MEM_valid_i     = 1'b1;
        WB_MEM_get_i    = 1'b0;
        tick();
        tick();
        chk("rst.get", 32'(MEM_EX_get_o), 32'd1);
        chk("rst.strobes", {30'd0, MEM_read_o, MEM_write_o}, 32'd0);
        chk("rst.be", 32'(MEM_be_o), 32'd0);
        chk("rst.addr", MEM_addr_o, 32'd0);
        chk("rst.wdata", MEM_data_o, 32'd0);
        chk("rst.give", 32'(MEM_WB_give_o), 32'd0);
        chk("rst.err", 32'(MEM_WB_err_o), 32'd0);
        chk("rst.wb_data", MEM_WB_data_o, 32'd0);
        chk("rst.wb_instr", MEM_WB_instr_o, 32'd0);
        EX_MEM_give_i = 1'b0;
        MEM_valid_i   = 1'b0;
        resetn_i      = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Reset in the middle of an access: strobes drop, pending work is discarded
        EX_MEM_give_i   = 1'b1;
        EX_MEM_instr_i  = mk(7'h03, 3'd2);
        EX_MEM_result_i = 32'h80;
        tick();
        EX_MEM_give_i = 1'b0;
        chk("midrst.read_before", 32'(MEM_read_o), 32'd1);
        resetn_i = 1'b0;
        tick();
        chk("midrst.strobes", {30'd0, MEM_read_o, MEM_write_o}, 32'd0);
        chk("midrst.get", 32'(MEM_EX_get_o), 32'd1);
        chk("midrst.give", 32'(MEM_WB_give_o), 32'd0);
        resetn_i     = 1'b1;
        WB_MEM_get_i = 1'b0;
        MEM_valid_i  = 1'b1;
        MEM_data_i   = 32'h1111_2222;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("midrst.idle_give%0d", k), 32'(MEM_WB_give_o), 32'd0);
            chk($sformatf("midrst.idle_strobes%0d", k), {30'd0, MEM_read_o, MEM_write_o}, 32'd0);
            chk($sformatf("midrst.idle_get%0d", k), 32'(MEM_EX_get_o), 32'd1);
        end
        MEM_valid_i = 1'b0;

        // Randomized transactions checked against the reference model
        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 2) begin
                instr = mk(nm_ops[$urandom_range(0, 3)], 3'($urandom_range(0, 7)));
                res   = $urandom;
            end else begin
                if (kind <= 6) begin
                    op = 3;
                    case ($urandom_range(0, 4))
                        0: f3 = 0;
                        1: f3 = 1;
                        2: f3 = 2;
                        3: f3 = 4;
                        default: f3 = 5;
                    endcase
                end else if (kind <= 8) begin
                    op = 35;
                    f3 = $urandom_range(0, 2);
                end else begin
                    op = 3;
                    f3 = 3;
                end
                instr = mk(7'(op), 3'(f3));
                res   = 32'($urandom_range(0, 4095));
            end
            rv = model(instr, res, $urandom, $urandom,
                       ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5)));
            run_vec($sformatf("rnd%0d", t), rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
